// File: rtl/fetch_unit_pkg.sv
// Shared pipeline stage register types and fetch-stage constants.
package fetch_unit_pkg;

    localparam logic [31:0] RISCV_NOP             = 32'h0000_0013;
    localparam int          FETCH_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fetched_inst;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry FIFO with push, pop, flush and occupancy count.
// Used both for returned {pc, inst} words and for the in-flight request PC queue.
module fetch_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests, buffers up to two words, drives IF_ID.
// Defining FETCH_PERF_CNT_EN adds the perf_fetched / perf_bubbles counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = RISCV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output if_id_t      if_id_reg
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    logic [31:0] pc_q;
    logic [1:0]  out_cnt;
    logic [1:0]  drop_cnt;
    logic [1:0]  fifo_cnt;
    logic [31:0] inflight_pc;
    if_id_t      fifo_head;
    if_id_t      push_entry;
    logic        pop;
    logic [2:0]  credit_sum;
    logic        req_fire;
    logic        resp_tracked;
    logic        resp_keep;

    assign pop            = !redirect_valid && !stall && (fifo_cnt != 2'd0);
    assign credit_sum     = {1'b0, out_cnt} + {1'b0, fifo_cnt} - {2'b00, pop};
    assign imem_req_valid = !reset && !redirect_valid
                            && (credit_sum < 3'(FETCH_MAX_OUTSTANDING));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight belong to pre-reset requests and are ignored.
    assign resp_tracked = imem_resp_valid && (out_cnt != 2'd0);
    assign resp_keep    = resp_tracked && (drop_cnt == 2'd0) && !redirect_valid;
    assign push_entry   = '{pc: inflight_pc, fetched_inst: imem_resp_data};

    // The in-flight PC queue occupancy is the outstanding-request count.
    fetch_buffer #(.W(32)) u_inflight (
        .clk       (clk),
        .rst       (reset),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_tracked),
        .flush     (1'b0),
        .head      (inflight_pc),
        .count     (out_cnt)
    );

    fetch_buffer #(.W(64)) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            drop_cnt  <= 2'd0;
            if_id_reg <= '{pc: 32'h0, fetched_inst: NOP_INST};
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~32'h3;
            drop_cnt <= out_cnt - {1'b0, resp_tracked};
            if_id_reg.fetched_inst <= NOP_INST;
        end else begin
            if (req_fire) pc_q <= pc_q + 32'd4;
            if (resp_tracked && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
            if (!stall) begin
                if (fifo_cnt != 2'd0) if_id_reg <= fifo_head;
                else                  if_id_reg.fetched_inst <= NOP_INST;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid || (!stall && (fifo_cnt == 2'd0)))
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model (data = addr ^ 0xA5A50000).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    if_id_t      if_id_reg;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic        fired;
    logic [31:0] fire_addr;
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_reg       (if_id_reg)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: present due memory response, record the handshake, return #1 after the edge.
    task automatic cycle();
        @(negedge clk);
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = q_addr.pop_front() ^ K;
            void'(q_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        fired     = imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        if (fired) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        if_id_t e;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        e = '{pc: 32'h0, fetched_inst: NOP};
        checks++;
        if (if_id_reg !== e) begin failures++; $display("FAIL reset_if_id got=%h want=%h", if_id_reg, e); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        checks++;
        if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h want=0", imem_req_addr); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] wpc, winst;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 1) begin
                checks++;
                if (fired !== 1'b1 || fire_addr !== 32'h0) begin
                    failures++; $display("FAIL first_request got fired=%b addr=%h want fired=1 addr=0", fired, fire_addr);
                end
            end
            wpc   = (k < 3) ? 32'h0 : 32'(4 * (k - 3));
            winst = (k < 3) ? NOP : (wpc ^ K);
            checks++;
            if (if_id_reg.pc !== wpc || if_id_reg.fetched_inst !== winst) begin
                failures++;
                $display("FAIL stream_c%0d got pc=%h inst=%h want pc=%h inst=%h", k, if_id_reg.pc, if_id_reg.fetched_inst, wpc, winst);
            end
        end
        exp_pc  = 32'h18;
        prev_pc = 32'h14;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held  = prev_pc;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (if_id_reg.pc !== held || if_id_reg.fetched_inst !== (held ^ K)) begin
                failures++; $display("FAIL stall_hold got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, held);
            end
            checks++;
            if (fired !== 1'b0) begin failures++; $display("FAIL stall_no_request got fired=%b want 0", fired); end
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                failures++; $display("FAIL stall_resume got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
            end
            prev_pc = exp_pc;
            exp_pc  = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        bit seen  = 0;
        lat = 2;
        for (int i = 0; i < 12 && !found; i++) begin
            if (q_addr.size() == 2) found = 1;
            else begin
                cycle();
                checks++;
                if (if_id_reg.fetched_inst === NOP) begin
                    if (if_id_reg.pc !== prev_pc) begin failures++; $display("FAIL redir_pre_bubble got pc=%h want %h", if_id_reg.pc, prev_pc); end
                end else begin
                    if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                        failures++; $display("FAIL redir_pre_stream got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
                    end
                    prev_pc = if_id_reg.pc; exp_pc = if_id_reg.pc + 32'd4;
                end
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL redir_two_in_flight got %0d in flight want 2", q_addr.size()); end

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (fired !== 1'b0) begin failures++; $display("FAIL redir_no_request got fired=%b want 0", fired); end
        checks++;
        if (if_id_reg.fetched_inst !== NOP || if_id_reg.pc !== prev_pc) begin
            failures++; $display("FAIL redir_bubble got pc=%h inst=%h want pc=%h inst=%h", if_id_reg.pc, if_id_reg.fetched_inst, prev_pc, NOP);
        end
        exp_pc = 32'h100;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) begin
                checks++;
                if (fired !== 1'b1 || fire_addr !== 32'h100) begin
                    failures++; $display("FAIL redir_target_req got fired=%b addr=%h want fired=1 addr=100", fired, fire_addr);
                end
            end
            checks++;
            if (if_id_reg.fetched_inst === NOP) begin
                if (if_id_reg.pc !== prev_pc) begin failures++; $display("FAIL redir_post_bubble got pc=%h want %h", if_id_reg.pc, prev_pc); end
            end else begin
                if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                    failures++; $display("FAIL redir_post_stream got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
                end
                if (if_id_reg.pc === 32'h100) seen = 1;
                prev_pc = if_id_reg.pc; exp_pc = if_id_reg.pc + 32'd4;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL redir_target_seen got no pc=100 want pc=100 on if_id"); end
        lat = 1;
    endtask

    task automatic test_ready_low();
        logic [31:0] held;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (if_id_reg.fetched_inst !== NOP) begin prev_pc = if_id_reg.pc; exp_pc = if_id_reg.pc + 32'd4; end
        end
        held = imem_req_addr;
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (imem_req_addr !== held || fired !== 1'b0) begin
                failures++; $display("FAIL ready_low_addr got addr=%h fired=%b want addr=%h fired=0", imem_req_addr, fired, held);
            end
            checks++;
            if (if_id_reg.fetched_inst === NOP) begin
                if (if_id_reg.pc !== prev_pc) begin failures++; $display("FAIL ready_low_bubble got pc=%h want %h", if_id_reg.pc, prev_pc); end
            end else begin
                if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                    failures++; $display("FAIL ready_low_stream got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
                end
                prev_pc = if_id_reg.pc; exp_pc = if_id_reg.pc + 32'd4;
            end
        end
        checks++;
        if (if_id_reg.fetched_inst !== NOP) begin failures++; $display("FAIL ready_low_drained got inst=%h want %h", if_id_reg.fetched_inst, NOP); end
        imem_req_ready = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b1 || fire_addr !== held) begin
            failures++; $display("FAIL ready_resume got fired=%b addr=%h want fired=1 addr=%h", fired, fire_addr, held);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (if_id_reg.fetched_inst === NOP) begin
                if (if_id_reg.pc !== prev_pc) begin failures++; $display("FAIL ready_resume_bubble got pc=%h want %h", if_id_reg.pc, prev_pc); end
            end else begin
                if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                    failures++; $display("FAIL ready_resume_stream got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
                end
                prev_pc = if_id_reg.pc; exp_pc = if_id_reg.pc + 32'd4;
            end
        end
    endtask

    task automatic test_async_reset();
        if_id_t e;
        @(posedge clk);
        #3;
        reset = 1'b1;
        imem_resp_valid = 1'b0;
        #1;
        e = '{pc: 32'h0, fetched_inst: NOP};
        checks++;
        if (if_id_reg !== e) begin failures++; $display("FAIL async_reset_if_id got=%h want=%h", if_id_reg, e); end
        checks++;
        if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_req got addr=%h valid=%b want addr=0 valid=0", imem_req_addr, imem_req_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin
            failures++; $display("FAIL perf_reset got fetched=%0d bubbles=%0d want 0 0", perf_fetched, perf_bubbles);
        end
`endif
        q_addr.delete();
        q_due.delete();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_pc  = 32'h0;
        prev_pc = 32'h0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 0) begin
                checks++;
                if (fired !== 1'b1 || fire_addr !== 32'h0) begin
                    failures++; $display("FAIL post_reset_req got fired=%b addr=%h want fired=1 addr=0", fired, fire_addr);
                end
            end
            if (if_id_reg.fetched_inst !== NOP) begin
                checks++;
                if (if_id_reg.pc !== exp_pc || if_id_reg.fetched_inst !== (exp_pc ^ K)) begin
                    failures++; $display("FAIL post_reset_stream got pc=%h inst=%h want pc=%h", if_id_reg.pc, if_id_reg.fetched_inst, exp_pc);
                end
                exp_pc = if_id_reg.pc + 32'd4;
            end
        end
        checks++;
        if (exp_pc !== 32'h10) begin failures++; $display("FAIL post_reset_progress got next_pc=%h want 00000010", exp_pc); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int n_fetch = 0;
        int n_nop   = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_resp_valid = 1'b0;
        q_addr.delete();
        q_due.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 30 && n_fetch < 10; k++) begin
            cycle();
            if (if_id_reg.fetched_inst === NOP) n_nop++;
            else n_fetch++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        n_nop++;
        checks++;
        if (perf_fetched !== 32'd10 || n_fetch != 10) begin
            failures++; $display("FAIL perf_fetched got=%0d seen=%0d want 10", perf_fetched, n_fetch);
        end
        checks++;
        if (perf_bubbles !== 32'(n_nop)) begin
            failures++; $display("FAIL perf_bubbles got=%0d want=%0d", perf_bubbles, n_nop);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ready_low();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
